rob_recovery_walker: RTL and testbench
======================================

// Module: rob_recovery_walker
// PURPOSE
//  Sequences ROB recovery after a branch mispredict or a memory-order violation.
//  Freezes commit and dispatch, then walks squashed entries youngest-first, 2 per cycle.
//  Each walked entry restores one RAT mapping and returns one physical tag to the freelist.
//  Finishes by publishing the new ROB tail and count. Sits between the ROB, RAT, freelist and dispatch stall logic.
// PARAMETERS
//  ROB_NUM      32  ROB entries (power of 2)
//  ROB_SEL      5   log2(ROB_NUM)
//  REG_SEL      5   architectural register index width
//  PHY_REG_SEL  6   physical register tag width
// PORTS
//  clk               in   1            clock
//  reset             in   1            synchronous, active-high
//  prmiss            in   1            branch mispredict; keep the branch, squash younger
//  prmiss_rob_idx    in   ROB_SEL      ROB index of the mispredicted branch
//  violation         in   1            order violation; squash the load and younger
//  violation_rob_idx in   ROB_SEL      ROB index of the violating load
//  rob_head          in   ROB_SEL      index of the oldest ROB entry
//  rob_count         in   ROB_SEL+1    valid ROB entries
//  walk_idx_1/2      out  ROB_SEL      ROB read-port addresses for this cycle
//  walk_dst_1/2      in   REG_SEL      arch dst read at walk_idx_1/2 (0 = no dst)
//  walk_ori_1/2      in   PHY_REG_SEL  previous mapping (phy_ori_dst)
//  walk_new_1/2      in   PHY_REG_SEL  tag allocated by this entry
//  squash_valid_1/2  out  1            clear ROB valid at walk_idx_1/2
//  rollback_valid_1/2 out 1            RAT restore plus freelist return
//  rollback_dst_1/2  out  REG_SEL      RAT entry to restore (= walk_dst)
//  rollback_tag_1/2  out  PHY_REG_SEL  tag written into RAT (= walk_ori)
//  release_tag_1/2   out  PHY_REG_SEL  tag returned to freelist (= walk_new)
//  recovering        out  1            stall dispatch and block commit
//  recover_done      out  1            one-cycle pulse; ROB loads new_tail/new_count
//  new_tail          out  ROB_SEL      youngest kept index = (head - keep + 1) mod ROB_NUM
//  new_count         out  ROB_SEL+1    kept entries (= keep)
// BEHAVIOUR
//  Age and distance:
//   - dist(x) = (rob_head - x) mod ROB_NUM, since the ROB allocates downward.
//   - Smaller dist means older.
//   - keep = dist(prmiss_idx)+1 for a mispredict; keep = dist(violation_idx) for a violation.
//  States: IDLE, WALK, DONE.
//  IDLE:
//   - On prmiss|violation at cycle T: recovering=1 combinationally in T, so the ROB commits nothing in T.
//   - Latch head and the lowest keep. If both requests fire, the smaller keep wins.
//   - Set walk_dist = rob_count-1.
//   - Go to WALK if rob_count > keep, otherwise go to DONE.
//  WALK:
//   - Slot 1 = entry at walk_dist; slot 2 = entry at walk_dist-1.
//   - walk_idx = (head - dist) mod ROB_NUM.
//   - A slot is active if its dist >= keep. squash_valid = active.
//   - rollback_valid = active && walk_dst != 0.
//   - Slot 1 is younger: the RAT applies slot 1, then slot 2; a same-dst conflict resolves to slot 2.
//   - walk_dist -= number of active slots. Go to DONE when the next walk_dist < keep.
//   - Rollback outputs are combinational from the read data in the same cycle (0-cycle read).
//  DONE:
//   - recover_done=1 with new_tail and new_count; recovering=1.
//   - Next state is IDLE; recovering drops at T+2+ceil(k/2), where k = squashed entries.
//  New request in WALK or DONE:
//   - Recompute keep against the latched head.
//   - If the new keep < current keep, adopt it and continue or re-enter WALK.
//   - Otherwise ignore it; it is already covered.
//   - Requests in IDLE's trigger cycle and in DONE follow the same rule. A DONE with a pending extension becomes WALK with no pulse.
//  Wrap-around:
//   - All index math is mod ROB_NUM.
//   - keep=0 gives new_tail=(head+1) mod ROB_NUM, i.e. an empty ROB.
//  Reset:
//   - Any state goes to IDLE, including mid-walk.
//   - All outputs 0; walk_idx 0; new_tail 0; new_count 0.
// TESTING
//  T1 head=31 count=10, prmiss idx 27 (keep 5)
//     -> walk {22,23},{24,25},{26,-}; done at T+4, new_tail=27, new_count=5.
//  T2 head=31 count=3, violation idx 31 (keep 0)
//     -> walk {29,30},{31,-}; new_tail=0, new_count=0.
//  T3 wrap: head=2 count=6 (entries 2,1,0,31,30,29), prmiss idx 0 (keep 3)
//     -> walk {29,30},{31,-}; new_tail=0, new_count=3.
//  T4 same cycle: prmiss dist 5 and violation dist 3
//     -> keep=3; recovering=1 in T; no commit in T.
//  T5 mid-walk: older violation -> walk extends to the new keep, one pulse only; younger request -> ignored.
//  T6 prmiss at youngest (k=0) -> no squash, done at T+1, new_tail=tail.
//     Reset asserted mid-WALK -> IDLE with all outputs 0 next cycle.

Source files
------------

// File: rtl/rob_recovery_walker.sv
// rob_recovery_walker
//   Sequences ROB recovery after a branch mispredict or a memory-order
//   violation. While it runs it holds commit and dispatch off. It walks the
//   squashed entries youngest-first, two per cycle. Every walked entry that
//   has a destination restores one RAT mapping and returns one physical tag
//   to the freelist. At the end it publishes the new ROB tail and count.
//
// Ports
//   clk, reset               clock; synchronous active-high reset
//   prmiss, prmiss_rob_idx   mispredicted branch; the branch itself is kept
//   violation, violation_rob_idx
//                            violating load; the load itself is squashed
//   rob_head, rob_count      current ROB head index and number of valid entries
//   walk_idx_1/2             ROB read addresses for this cycle's two slots
//   walk_dst/ori/new_1/2     ROB read data for those addresses (0-cycle read)
//   squash_valid_1/2         clear the ROB valid bit at walk_idx_1/2
//   rollback_valid/dst/tag_1/2
//                            RAT restore (dst <- ori); slot 2 is applied last
//   release_tag_1/2          tag returned to the freelist
//   recovering               stall dispatch and block commit
//   recover_done             one-cycle pulse with new_tail / new_count
module rob_recovery_walker #(
  parameter int ROB_NUM     = 32,
  parameter int ROB_SEL     = 5,
  parameter int REG_SEL     = 5,
  parameter int PHY_REG_SEL = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   prmiss,
  input  logic [ROB_SEL-1:0]     prmiss_rob_idx,
  input  logic                   violation,
  input  logic [ROB_SEL-1:0]     violation_rob_idx,
  input  logic [ROB_SEL-1:0]     rob_head,
  input  logic [ROB_SEL:0]       rob_count,
  output logic [ROB_SEL-1:0]     walk_idx_1,
  output logic [ROB_SEL-1:0]     walk_idx_2,
  input  logic [REG_SEL-1:0]     walk_dst_1,
  input  logic [REG_SEL-1:0]     walk_dst_2,
  input  logic [PHY_REG_SEL-1:0] walk_ori_1,
  input  logic [PHY_REG_SEL-1:0] walk_ori_2,
  input  logic [PHY_REG_SEL-1:0] walk_new_1,
  input  logic [PHY_REG_SEL-1:0] walk_new_2,
  output logic                   squash_valid_1,
  output logic                   squash_valid_2,
  output logic                   rollback_valid_1,
  output logic                   rollback_valid_2,
  output logic [REG_SEL-1:0]     rollback_dst_1,
  output logic [REG_SEL-1:0]     rollback_dst_2,
  output logic [PHY_REG_SEL-1:0] rollback_tag_1,
  output logic [PHY_REG_SEL-1:0] rollback_tag_2,
  output logic [PHY_REG_SEL-1:0] release_tag_1,
  output logic [PHY_REG_SEL-1:0] release_tag_2,
  output logic                   recovering,
  output logic                   recover_done,
  output logic [ROB_SEL-1:0]     new_tail,
  output logic [ROB_SEL:0]       new_count
);

  // Walk distance carries a sign bit so that "one past the oldest entry"
  // (-1) is representable when keep is 0.
  localparam int WD_W = ROB_SEL + 2;
  localparam logic [ROB_SEL:0]   ONE_K = 1;
  localparam logic [ROB_SEL-1:0] ONE_I = 1;

  typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;

  // The ROB allocates downward, so age is measured as head minus index.
  function automatic logic [ROB_SEL:0] dist_of(input logic [ROB_SEL-1:0] head,
                                               input logic [ROB_SEL-1:0] idx);
    logic [ROB_SEL-1:0] d;
    d = head - idx;
    return {1'b0, d};
  endfunction

  function automatic logic [ROB_SEL:0] min_keep(input logic [ROB_SEL:0] a,
                                                input logic [ROB_SEL:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic signed [WD_W-1:0] to_wd(input logic [ROB_SEL:0] k);
    return $signed({1'b0, k});
  endfunction

  state_t state, state_nxt;

  logic [ROB_SEL-1:0]     head_p1, head_nxt;
  logic [ROB_SEL:0]       keep_p1, keep_nxt;
  logic signed [WD_W-1:0] wd_p1, wd_nxt;

  logic [ROB_SEL-1:0]     base_head;
  logic [ROB_SEL:0]       pm_keep, vi_keep, req_keep;
  logic                   req_any, extend;
  logic signed [WD_W-1:0] wd2, n_act, wd_walked, keep_s, req_keep_s;
  logic                   act1, act2;

  // A request is measured against the live head when it triggers recovery,
  // and against the latched head once a recovery is in progress.
  always_comb begin
    base_head = (state == IDLE) ? rob_head : head_p1;
    pm_keep   = dist_of(base_head, prmiss_rob_idx) + ONE_K;
    vi_keep   = dist_of(base_head, violation_rob_idx);
    req_any   = prmiss | violation;
    if (prmiss && violation) req_keep = min_keep(pm_keep, vi_keep);
    else if (prmiss)         req_keep = pm_keep;
    else                     req_keep = vi_keep;
    req_keep_s = to_wd(req_keep);
    keep_s     = to_wd(keep_p1);
    extend     = req_any && (req_keep < keep_p1);
  end

  // Slot 1 is the younger entry (larger distance), slot 2 the next older one.
  always_comb begin
    wd2       = wd_p1 - to_wd(ONE_K);
    act1      = (state == WALK) && (wd_p1 >= keep_s);
    act2      = (state == WALK) && (wd2 >= keep_s);
    n_act     = to_wd({{(ROB_SEL-1){1'b0}}, act1 & act2, act1 ^ act2});
    wd_walked = wd_p1 - n_act;
  end

  always_comb begin
    walk_idx_1       = '0;
    walk_idx_2       = '0;
    if (state == WALK) begin
      walk_idx_1 = head_p1 - wd_p1[ROB_SEL-1:0];
      walk_idx_2 = head_p1 - wd2[ROB_SEL-1:0];
    end
    squash_valid_1   = act1;
    squash_valid_2   = act2;
    rollback_valid_1 = act1 && (walk_dst_1 != '0);
    rollback_valid_2 = act2 && (walk_dst_2 != '0);
    rollback_dst_1   = rollback_valid_1 ? walk_dst_1 : '0;
    rollback_dst_2   = rollback_valid_2 ? walk_dst_2 : '0;
    rollback_tag_1   = rollback_valid_1 ? walk_ori_1 : '0;
    rollback_tag_2   = rollback_valid_2 ? walk_ori_2 : '0;
    release_tag_1    = rollback_valid_1 ? walk_new_1 : '0;
    release_tag_2    = rollback_valid_2 ? walk_new_2 : '0;
  end

  always_comb begin
    state_nxt    = state;
    head_nxt     = head_p1;
    keep_nxt     = keep_p1;
    wd_nxt       = wd_p1;
    recovering   = 1'b0;
    recover_done = 1'b0;
    new_tail     = '0;
    new_count    = '0;
    unique case (state)
      IDLE: begin
        if (req_any) begin
          recovering = 1'b1;
          head_nxt   = rob_head;
          keep_nxt   = req_keep;
          wd_nxt     = to_wd(rob_count) - to_wd(ONE_K);
          state_nxt  = (rob_count > req_keep) ? WALK : DONE;
        end
      end
      WALK: begin
        recovering = 1'b1;
        wd_nxt     = wd_walked;
        // An older request only lowers keep; the walk simply runs further.
        if (extend) begin
          keep_nxt  = req_keep;
          state_nxt = (wd_walked < req_keep_s) ? DONE : WALK;
        end else begin
          state_nxt = (wd_walked < keep_s) ? DONE : WALK;
        end
      end
      DONE: begin
        recovering = 1'b1;
        if (extend) begin
          // Suppress the pulse; the ROB must not load a tail that is stale.
          keep_nxt  = req_keep;
          state_nxt = (wd_p1 >= req_keep_s) ? WALK : DONE;
        end else begin
          recover_done = 1'b1;
          new_tail     = head_p1 - keep_p1[ROB_SEL-1:0] + ONE_I;
          new_count    = keep_p1;
          state_nxt    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- stage p1: recovery control state and latched walk context ----
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    head_p1 <= head_nxt;
    keep_p1 <= keep_nxt;
    wd_p1   <= wd_nxt;
  end

endmodule

// File: tb/tb_rob_recovery_walker.sv
module tb_rob_recovery_walker;

  logic       clk = 1'b0;
  logic       reset;
  logic       prmiss, violation;
  logic [4:0] prmiss_rob_idx, violation_rob_idx, rob_head;
  logic [5:0] rob_count;
  logic [4:0] walk_idx_1, walk_idx_2;
  logic [4:0] walk_dst_1, walk_dst_2;
  logic [5:0] walk_ori_1, walk_ori_2, walk_new_1, walk_new_2;
  logic       squash_valid_1, squash_valid_2;
  logic       rollback_valid_1, rollback_valid_2;
  logic [4:0] rollback_dst_1, rollback_dst_2;
  logic [5:0] rollback_tag_1, rollback_tag_2, release_tag_1, release_tag_2;
  logic       recovering, recover_done;
  logic [4:0] new_tail;
  logic [5:0] new_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // ROB contents: entries whose index is 3 mod 4 have no destination,
  // otherwise dst = index, ori = index + 1, new = index + 32.
  function automatic logic [4:0] dst_f(input logic [4:0] i);
    return (i[1:0] == 2'd3) ? 5'd0 : i;
  endfunction
  assign walk_dst_1 = dst_f(walk_idx_1);
  assign walk_dst_2 = dst_f(walk_idx_2);
  assign walk_ori_1 = {1'b0, walk_idx_1} + 6'd1;
  assign walk_ori_2 = {1'b0, walk_idx_2} + 6'd1;
  assign walk_new_1 = {1'b1, walk_idx_1};
  assign walk_new_2 = {1'b1, walk_idx_2};

  rob_recovery_walker dut (
    .clk(clk), .reset(reset),
    .prmiss(prmiss), .prmiss_rob_idx(prmiss_rob_idx),
    .violation(violation), .violation_rob_idx(violation_rob_idx),
    .rob_head(rob_head), .rob_count(rob_count),
    .walk_idx_1(walk_idx_1), .walk_idx_2(walk_idx_2),
    .walk_dst_1(walk_dst_1), .walk_dst_2(walk_dst_2),
    .walk_ori_1(walk_ori_1), .walk_ori_2(walk_ori_2),
    .walk_new_1(walk_new_1), .walk_new_2(walk_new_2),
    .squash_valid_1(squash_valid_1), .squash_valid_2(squash_valid_2),
    .rollback_valid_1(rollback_valid_1), .rollback_valid_2(rollback_valid_2),
    .rollback_dst_1(rollback_dst_1), .rollback_dst_2(rollback_dst_2),
    .rollback_tag_1(rollback_tag_1), .rollback_tag_2(rollback_tag_2),
    .release_tag_1(release_tag_1), .release_tag_2(release_tag_2),
    .recovering(recovering), .recover_done(recover_done),
    .new_tail(new_tail), .new_count(new_count)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance to the next negedge and let combinational outputs settle.
  task automatic step();
    @(negedge clk);
    prmiss    = 1'b0;
    violation = 1'b0;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_walk(input string tag, input int i1, input int i2,
                          input int s1, input int s2);
    chk({tag, ".idx1"}, walk_idx_1, i1);
    if (s2) chk({tag, ".idx2"}, walk_idx_2, i2);
    chk({tag, ".sq1"}, squash_valid_1, s1);
    chk({tag, ".sq2"}, squash_valid_2, s2);
    chk({tag, ".rec"}, recovering, 1);
    chk({tag, ".done"}, recover_done, 0);
  endtask

  task automatic chk_done(input string tag, input int tail, input int cnt);
    chk({tag, ".done"}, recover_done, 1);
    chk({tag, ".rec"}, recovering, 1);
    chk({tag, ".tail"}, new_tail, tail);
    chk({tag, ".count"}, new_count, cnt);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".rec"}, recovering, 0);
    chk({tag, ".done"}, recover_done, 0);
    chk({tag, ".sq1"}, squash_valid_1, 0);
    chk({tag, ".sq2"}, squash_valid_2, 0);
    chk({tag, ".rb1"}, rollback_valid_1, 0);
    chk({tag, ".rb2"}, rollback_valid_2, 0);
    chk({tag, ".idx1"}, walk_idx_1, 0);
    chk({tag, ".idx2"}, walk_idx_2, 0);
    chk({tag, ".tail"}, new_tail, 0);
    chk({tag, ".count"}, new_count, 0);
  endtask

  initial begin
    reset = 1'b1;
    prmiss = 1'b0; violation = 1'b0;
    prmiss_rob_idx = '0; violation_rob_idx = '0;
    rob_head = '0; rob_count = '0;
    repeat (2) @(negedge clk);
    settle();
    chk_quiet("reset");
    step(); reset = 1'b0;
    settle();
    chk_quiet("idle");

    // T1: head 31, 10 entries, mispredict at 27 keeps 5
    step(); rob_head = 5'd31; rob_count = 6'd10;
    prmiss = 1'b1; prmiss_rob_idx = 5'd27;
    settle();
    chk("t1.trig.rec", recovering, 1);
    chk("t1.trig.done", recover_done, 0);
    step(); settle();
    chk_walk("t1.w1", 22, 23, 1, 1);
    chk("t1.w1.rb1", rollback_valid_1, 1);
    chk("t1.w1.dst1", rollback_dst_1, 22);
    chk("t1.w1.tag1", rollback_tag_1, 23);
    chk("t1.w1.rel1", release_tag_1, 54);
    chk("t1.w1.rb2", rollback_valid_2, 0);
    step(); settle();
    chk_walk("t1.w2", 24, 25, 1, 1);
    chk("t1.w2.rb2", rollback_valid_2, 1);
    chk("t1.w2.dst2", rollback_dst_2, 25);
    chk("t1.w2.tag2", rollback_tag_2, 26);
    chk("t1.w2.rel2", release_tag_2, 57);
    step(); settle();
    chk_walk("t1.w3", 26, 0, 1, 0);
    chk("t1.w3.rb2", rollback_valid_2, 0);
    step(); settle();
    chk_done("t1.end", 27, 5);
    step(); settle();
    chk_quiet("t1.after");

    // T2: violation at the head keeps nothing
    step(); rob_head = 5'd31; rob_count = 6'd3;
    violation = 1'b1; violation_rob_idx = 5'd31;
    settle();
    chk("t2.trig.rec", recovering, 1);
    step(); settle();
    chk_walk("t2.w1", 29, 30, 1, 1);
    step(); settle();
    chk_walk("t2.w2", 31, 0, 1, 0);
    step(); settle();
    chk_done("t2.end", 0, 0);
    step(); settle();
    chk("t2.after.rec", recovering, 0);

    // T3: index wrap, head 2, mispredict at 0 keeps 3
    step(); rob_head = 5'd2; rob_count = 6'd6;
    prmiss = 1'b1; prmiss_rob_idx = 5'd0;
    settle();
    step(); settle();
    chk_walk("t3.w1", 29, 30, 1, 1);
    step(); settle();
    chk_walk("t3.w2", 31, 0, 1, 0);
    step(); settle();
    chk_done("t3.end", 0, 3);
    step(); settle();

    // T4: same-cycle requests, violation (keep 3) beats mispredict (keep 6)
    step(); rob_head = 5'd31; rob_count = 6'd10;
    prmiss = 1'b1; prmiss_rob_idx = 5'd26;
    violation = 1'b1; violation_rob_idx = 5'd28;
    settle();
    chk("t4.trig.rec", recovering, 1);
    step(); settle(); chk_walk("t4.w1", 22, 23, 1, 1);
    step(); settle(); chk_walk("t4.w2", 24, 25, 1, 1);
    step(); settle(); chk_walk("t4.w3", 26, 27, 1, 1);
    step(); settle(); chk_walk("t4.w4", 28, 0, 1, 0);
    step(); settle(); chk_done("t4.end", 29, 3);
    step(); settle();

    // T5: older violation mid-walk extends; younger mispredict is ignored
    step(); rob_head = 5'd31; rob_count = 6'd10;
    prmiss = 1'b1; prmiss_rob_idx = 5'd25;
    settle();
    step(); violation = 1'b1; violation_rob_idx = 5'd29;
    settle(); chk_walk("t5.w1", 22, 23, 1, 1);
    step(); prmiss = 1'b1; prmiss_rob_idx = 5'd20;
    settle(); chk_walk("t5.w2", 24, 25, 1, 1);
    step(); settle(); chk_walk("t5.w3", 26, 27, 1, 1);
    step(); settle(); chk_walk("t5.w4", 28, 29, 1, 1);
    step(); settle(); chk_done("t5.end", 30, 2);
    step(); settle();
    chk_quiet("t5.after");

    // T6: mispredict at the youngest entry squashes nothing
    step(); rob_head = 5'd31; rob_count = 6'd4;
    prmiss = 1'b1; prmiss_rob_idx = 5'd28;
    settle();
    step(); settle();
    chk("t6.sq1", squash_valid_1, 0);
    chk_done("t6.end", 28, 4);
    step(); settle();
    chk_quiet("t6.after");

    // Reset in the middle of a walk
    step(); rob_head = 5'd31; rob_count = 6'd10;
    prmiss = 1'b1; prmiss_rob_idx = 5'd27;
    settle();
    step(); settle();
    chk_walk("rst.w1", 22, 23, 1, 1);
    step(); reset = 1'b1;
    settle();
    step(); reset = 1'b0;
    settle();
    chk_quiet("rst.after");
    step(); settle();
    chk_quiet("rst.idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
